// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage datapath and its sequencer.
// The master side is the datapath; the slave side is the hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       idRs1;
    logic [4:0]       idRs2;
    logic             idUseRs1;
    logic             idUseRs2;
    logic             exMemRead;
    logic [4:0]       exRd;
    logic             exTaken;
    logic             dmemReq;
    logic             dmemReady;
    logic             pcWrite;
    logic             ifIdWrite;
    logic             ifIdFlush;
    logic             idExWrite;
    logic             idExFlush;
    logic             exMemWrite;
    logic             memWbFlush;
    logic [CNT_W-1:0] stallCnt;
    logic             memErr;

    modport master (
        output idRs1, idRs2, idUseRs1, idUseRs2, exMemRead, exRd, exTaken, dmemReq, dmemReady,
        input  pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite, memWbFlush,
        input  stallCnt, memErr
    );

    modport slave (
        input  idRs1, idRs2, idUseRs1, idUseRs2, exMemRead, exRd, exTaken, dmemReq, dmemReady,
        output pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite, memWbFlush,
        output stallCnt, memErr
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: post-reset flush, load-use bubbles, EX-resolved branch squash
// and data-memory freeze, with a saturating stall counter and a sticky memory timeout flag.
module pipeline_hazard_ctrl #(
    parameter int INIT_CYC    = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rstN,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int IW = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    init_cnt_q, init_cnt_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             mem_err_q, mem_err_d;

    logic load_use;
    logic mem_stall;
    logic freeze;
    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush;

    assign load_use  = hz.exMemRead && (hz.exRd != 5'd0) &&
                       ((hz.idUseRs1 && (hz.idRs1 == hz.exRd)) ||
                        (hz.idUseRs2 && (hz.idRs2 == hz.exRd)));
    assign mem_stall = hz.dmemReq && !hz.dmemReady;

    // A pending branch or load-use is held back while frozen and resolved on the ready cycle.
    assign freeze = ((state_q == ST_RUN) && mem_stall) ||
                    ((state_q == ST_MEM_WAIT) && !hz.dmemReady);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        mem_wb_flush = 1'b0;

        if (state_q == ST_INIT) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_write  = 1'b0;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (hz.exTaken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        mem_err_d   = mem_err_q;

        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == IW'(INIT_CYC - 1)) begin
                    state_d    = ST_RUN;
                    init_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (mem_stall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WW'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (hz.dmemReady) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    if (wait_cnt_q != WW'(MEM_TIMEOUT)) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                    if (wait_cnt_d == WW'(MEM_TIMEOUT)) begin
                        mem_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        if ((state_q != ST_INIT) && !pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign hz.pcWrite    = pc_write;
    assign hz.ifIdWrite  = if_id_write;
    assign hz.ifIdFlush  = if_id_flush;
    assign hz.idExWrite  = id_ex_write;
    assign hz.idExFlush  = id_ex_flush;
    assign hz.exMemWrite = ex_mem_write;
    assign hz.memWbFlush = mem_wb_flush;
    assign hz.stallCnt   = stall_cnt_q;
    assign hz.memErr     = mem_err_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;
    localparam int INIT_CYC    = 4;
    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_W       = 4;
    localparam int STALL_MAX   = (1 << CNT_W) - 1;

    // Control word order: pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush, exMemWrite, memWbFlush
    localparam logic [6:0] PAT_INIT   = 7'b0010111;
    localparam logic [6:0] PAT_FREEZE = 7'b0000001;
    localparam logic [6:0] PAT_TAKEN  = 7'b1111110;
    localparam logic [6:0] PAT_BUBBLE = 7'b0001110;
    localparam logic [6:0] PAT_NORMAL = 7'b1101010;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    int checks = 0;
    int errors = 0;

    int mMode   = 0;
    int mInit   = 0;
    int mFrozen = 0;
    int mStall  = 0;
    int mErr    = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipeline_hazard_ctrl #(
        .INIT_CYC   (INIT_CYC),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk (clk),
        .rstN(rstN),
        .hz  (hz.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs shortly after the rising edge.
    task automatic applyStimulus(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                                 input logic u1, input logic [4:0] r2, input logic u2,
                                 input logic taken, input logic req, input logic ready);
        @(posedge clk);
        #1;
        hz.exMemRead = mr;
        hz.exRd      = rd;
        hz.idRs1     = r1;
        hz.idUseRs1  = u1;
        hz.idRs2     = r2;
        hz.idUseRs2  = u2;
        hz.exTaken   = taken;
        hz.dmemReq   = req;
        hz.dmemReady = ready;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1 rstN = 1'b0;
        @(posedge clk);
        #1 rstN = 1'b1;
        repeat (INIT_CYC) @(posedge clk);
    endtask

    // Reference model: expected outputs from the hazard rules, then advance the model state.
    always @(negedge clk) begin : compare
        logic [6:0] expCtrl;
        logic       lu;
        logic       frz;
        if (!rstN) begin
            mMode   = 0;
            mInit   = 0;
            mFrozen = 0;
            mStall  = 0;
            mErr    = 0;
            expCtrl = PAT_INIT;
            frz     = 1'b0;
        end else begin
            lu  = hz.exMemRead && (hz.exRd != 0) &&
                  ((hz.idUseRs1 && hz.idRs1 == hz.exRd) || (hz.idUseRs2 && hz.idRs2 == hz.exRd));
            frz = (mMode == 1 && hz.dmemReq && !hz.dmemReady) || (mMode == 2 && !hz.dmemReady);
            if (mMode == 0)      expCtrl = PAT_INIT;
            else if (frz)        expCtrl = PAT_FREEZE;
            else if (hz.exTaken) expCtrl = PAT_TAKEN;
            else if (lu)         expCtrl = PAT_BUBBLE;
            else                 expCtrl = PAT_NORMAL;
        end

        checkOutput("ctrl", {hz.pcWrite, hz.ifIdWrite, hz.ifIdFlush, hz.idExWrite,
                             hz.idExFlush, hz.exMemWrite, hz.memWbFlush}, expCtrl);
        checkOutput("stallCnt", hz.stallCnt, mStall);
        checkOutput("memErr", hz.memErr, mErr);

        if (rstN) begin
            if (mMode != 0 && !expCtrl[6]) mStall = (mStall < STALL_MAX) ? mStall + 1 : STALL_MAX;
            case (mMode)
                0: begin
                    mInit++;
                    if (mInit == INIT_CYC) mMode = 1;
                end
                1: if (frz) begin
                    mMode   = 2;
                    mFrozen = 1;
                end
                default: if (frz) begin
                    mFrozen++;
                    if (mFrozen >= MEM_TIMEOUT) mErr = 1;
                end else begin
                    mMode = 1;
                end
            endcase
        end
    end

    initial begin
        hz.exMemRead = 1'b0;
        hz.exRd      = 5'd0;
        hz.idRs1     = 5'd0;
        hz.idUseRs1  = 1'b0;
        hz.idRs2     = 5'd0;
        hz.idUseRs2  = 1'b0;
        hz.exTaken   = 1'b0;
        hz.dmemReq   = 1'b0;
        hz.dmemReady = 1'b1;

        // Reset release: exactly INIT_CYC flushed cycles
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        #2;
        checkOutput("init pcWrite c0", hz.pcWrite, 0);
        checkOutput("init ifIdFlush c0", hz.ifIdFlush, 1);
        for (int i = 1; i < INIT_CYC; i++) begin
            @(posedge clk);
            #3;
            checkOutput("init pcWrite", hz.pcWrite, 0);
        end
        @(posedge clk);
        #3;
        checkOutput("run pcWrite", hz.pcWrite, 1);
        checkOutput("run ifIdFlush", hz.ifIdFlush, 0);
        checkOutput("run stallCnt", hz.stallCnt, 0);

        // Load-use bubble, then rd=x0
        applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        checkOutput("lu pcWrite", hz.pcWrite, 0);
        checkOutput("lu ifIdWrite", hz.ifIdWrite, 0);
        checkOutput("lu idExFlush", hz.idExFlush, 1);
        applyStimulus(1'b0, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        checkOutput("lu after pcWrite", hz.pcWrite, 1);
        checkOutput("lu stallCnt", hz.stallCnt, 1);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        #2;
        checkOutput("x0 pcWrite", hz.pcWrite, 1);

        // Taken branch overrides load-use
        applyStimulus(1'b1, 5'd7, 5'd3, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        #2;
        checkOutput("br pcWrite", hz.pcWrite, 1);
        checkOutput("br ifIdFlush", hz.ifIdFlush, 1);
        checkOutput("br idExFlush", hz.idExFlush, 1);
        idle();
        #2;
        checkOutput("br stallCnt", hz.stallCnt, 1);

        // Memory freeze for 3 cycles, then ready
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            #2;
            checkOutput("frz exMemWrite", hz.exMemWrite, 0);
            checkOutput("frz memWbFlush", hz.memWbFlush, 1);
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        checkOutput("rdy pcWrite", hz.pcWrite, 1);
        checkOutput("rdy memWbFlush", hz.memWbFlush, 0);
        checkOutput("rdy stallCnt", hz.stallCnt, 3);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            #2;
            checkOutput("frzbr ifIdFlush", hz.ifIdFlush, 0);
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        #2;
        checkOutput("rdybr ifIdFlush", hz.ifIdFlush, 1);
        checkOutput("rdybr stallCnt", hz.stallCnt, 6);

        // Timeout: memErr visible after the 8th frozen cycle, sticky until reset
        for (int i = 1; i <= MEM_TIMEOUT + 1; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            #2;
            checkOutput("tmo memErr", hz.memErr, (i > MEM_TIMEOUT) ? 1 : 0);
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        checkOutput("tmo sticky", hz.memErr, 1);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        rstN = 1'b0;
        #2;
        checkOutput("rst memErr", hz.memErr, 0);
        checkOutput("rst ifIdFlush", hz.ifIdFlush, 1);
        checkOutput("rst pcWrite", hz.pcWrite, 0);
        idle();
        rstN = 1'b1;
        repeat (INIT_CYC) @(posedge clk);

        // Saturation of the stall counter
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
            idle();
        end
        #2;
        checkOutput("sat stallCnt", hz.stallCnt, STALL_MAX);

        // Randomized traffic, occasional resets
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 4) != 0));
            rstN = ($urandom_range(0, 199) != 0);
        end
        rstN = 1'b1;
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
